bidir_shift_reg: RTL and testbench
==================================

Name: bidir_shift_reg

Overview:
- Parameterisable bidirectional shift register with synchronous parallel load, left shift, right shift and hold.
- Mode is selected by a 2-bit code.
- Drives the lamp row in the handball (lampball) game; the "ball" is a lit bit moved left or right each clock.
- Single clock domain; asynchronous active-high clear.

Parameters:
- WIDTH, default 8: register width in bits; SRIN and SROUT are WIDTH bits wide.

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- CLEAR  input  1  asynchronous, active-high reset; forces SROUT to all zeros.
- SRIN  input  WIDTH  parallel load data.
- SEL  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- SIL  input  1  serial input for left shift; enters at bit 0.
- SIR  input  1  serial input for right shift; enters at bit WIDTH-1.
- SROUT  output  WIDTH  register contents, driven directly from flops with no combinational path from inputs.

Behaviour:
- Reset: while CLEAR=1, SROUT = 0 immediately, independent of CK. Reset overrides every SEL mode. CLEAR is asynchronous on both assertion and deassertion.
- After CLEAR falls, the first rising CK edge applies the current SEL.
- On each rising CK edge with CLEAR=0:
  - SEL=00 (hold): SROUT unchanged.
  - SEL=01 (shift right): SROUT <= {SIR, SROUT[WIDTH-1:1]}. Bit 0 is discarded.
  - SEL=10 (shift left): SROUT <= {SROUT[WIDTH-2:0], SIL}. Bit WIDTH-1 is discarded.
  - SEL=11 (parallel load): SROUT <= SRIN.
- Latency: one clock edge for every mode. SROUT reflects the new value immediately after the edge.
- No wrap-around: a bit shifted out is lost, not recirculated.
- SIL is ignored unless SEL=10. SIR is ignored unless SEL=01. SRIN is ignored unless SEL=11.
- SEL, SIL, SIR and SRIN are sampled only at the rising edge. Changes between edges have no effect.
- Any number of consecutive shifts is allowed. After WIDTH left shifts with SIL constant, SROUT is all-SIL (same for right shifts with SIR).
- Simultaneous CLEAR assertion and a clock edge: the clear wins and SROUT = 0.
- Clear asserted mid-shift: the sequence is abandoned. The register stays 0 while CLEAR=1.
- No X propagation from unused inputs. Power-up value is undefined until the first CLEAR.

Test Plan:
- Reset: CLEAR=1 with CK idle → SROUT=8'h00 without any clock edge. Deassert CLEAR, SEL=00, several edges → SROUT stays 8'h00.
- Parallel load then left shift:
  - SRIN=8'h80, SEL=11, one edge → SROUT=8'h80.
  - Then SEL=10, SIL=1, four edges → 8'h01, 8'h03, 8'h07, 8'h0F.
  - Then SIL=0, four edges → 8'h1E, 8'h3C, 8'h78, 8'hF0.
- Hold: SEL=00 from 8'hF0 for two edges with SIL, SIR and SRIN toggling → SROUT stays 8'hF0.
- Right shift:
  - Reload 8'h80 (SEL=11), then SEL=01, SIR=1, four edges → 8'hC0, 8'hE0, 8'hF0, 8'hF8.
  - Then SIR=0, four edges → 8'h7C, 8'h3E, 8'h1F, 8'h0F.
- Asynchronous clear mid-shift: from 8'h0F with SEL=01, raise CLEAR between edges → SROUT=8'h00 immediately, and stays 0 across edges while CLEAR=1.
- Shift-out boundary: load 8'h01, SEL=01, SIR=0, one edge → 8'h00. Load 8'h80, SEL=10, SIL=0, one edge → 8'h00.

Source files
------------

// File: rtl/bidir_shift_reg.sv
// Bidirectional shift register: hold, shift right, shift left, parallel load.
// Drives the lamp row of the lampball game; SROUT comes straight from flops.
module bidir_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             CLEAR,
    input  logic [WIDTH-1:0] SRIN,
    input  logic [1:0]       SEL,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] SROUT
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sir_msb;
    logic [WIDTH-1:0] sil_lsb;

    // Serial bits placed at their entry positions; works for WIDTH=1 too
    assign sir_msb = WIDTH'(SIR) << (WIDTH - 1);
    assign sil_lsb = WIDTH'(SIL);

    always_comb begin
        sr_d = sr_q;
        unique case (mode_e'(SEL))
            MODE_HOLD:  sr_d = sr_q;
            MODE_RIGHT: sr_d = (sr_q >> 1) | sir_msb;
            MODE_LEFT:  sr_d = (sr_q << 1) | sil_lsb;
            MODE_LOAD:  sr_d = SRIN;
        endcase
    end

    always_ff @(posedge CK or posedge CLEAR) begin
        if (CLEAR) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign SROUT = sr_q;

endmodule

// File: tb/tb_bidir_shift_reg.sv
// Directed and randomized bench for bidir_shift_reg against an arithmetic
// model of the shift/load rules.
module tb_bidir_shift_reg;

    localparam int W = 8;

    logic         CK    = 1'b0;
    logic         CLEAR = 1'b1;
    logic [W-1:0] SRIN  = '0;
    logic [1:0]   SEL   = 2'b00;
    logic         SIL   = 1'b0;
    logic         SIR   = 1'b0;
    logic [W-1:0] SROUT;

    int n_chk  = 0;
    int n_fail = 0;
    int model;

    bidir_shift_reg #(.WIDTH(W)) dut (
        .CK(CK),
        .CLEAR(CLEAR),
        .SRIN(SRIN),
        .SEL(SEL),
        .SIL(SIL),
        .SIR(SIR),
        .SROUT(SROUT)
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input int exp);
        logic [W-1:0] e;
        e = exp[W-1:0];
        n_chk++;
        assert (SROUT === e) else begin
            n_fail++;
            $error("FAIL %s: SROUT=%h expected %h", tag, SROUT, e);
        end
    endtask

    task automatic tick(input logic [1:0] s, input logic l, input logic r,
                        input logic [W-1:0] d);
        SEL  = s;
        SIL  = l;
        SIR  = r;
        SRIN = d;
        @(posedge CK);
        #1;
    endtask

    function automatic int ref_next(input int cur, input int s, input int l,
                                    input int r, input int d);
        int full;
        full = 1 << W;
        case (s)
            1:       return cur / 2 + r * (full / 2);
            2:       return (cur * 2) % full + l;
            3:       return d;
            default: return cur;
        endcase
    endfunction

    initial begin
        int exp_l [8];
        int exp_r [8];
        exp_l = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0};
        exp_r = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'h0F};

        #2;
        check("reset_no_edge", 0);
        @(posedge CK);
        #1;
        check("reset_held_edge", 0);
        #2 CLEAR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(2'b00, 1'b1, 1'b1, 8'hFF);
            check("hold_after_reset", 0);
        end

        tick(2'b11, 1'b0, 1'b0, 8'h80);
        check("load_80", 8'h80);
        for (int i = 0; i < 8; i++) begin
            tick(2'b10, (i < 4), 1'b0, 8'h55);
            check($sformatf("left_%0d", i), exp_l[i]);
        end

        tick(2'b00, 1'b1, 1'b1, 8'hFF);
        #2 begin SIL = 1'b0; SIR = 1'b0; SRIN = 8'h00; end
        check("hold_midcycle", 8'hF0);
        tick(2'b00, 1'b0, 1'b0, 8'h00);
        check("hold_2", 8'hF0);

        tick(2'b11, 1'b0, 1'b0, 8'h80);
        check("reload_80", 8'h80);
        for (int i = 0; i < 8; i++) begin
            tick(2'b01, 1'b0, (i < 4), 8'hAA);
            check($sformatf("right_%0d", i), exp_r[i]);
        end

        SEL = 2'b01;
        #2 CLEAR = 1'b1;
        #1 check("clear_async", 0);
        for (int i = 0; i < 3; i++) begin
            tick(2'b01, 1'b1, 1'b1, 8'hFF);
            check("clear_held", 0);
        end
        #2 CLEAR = 1'b0;

        tick(2'b11, 1'b0, 1'b0, 8'h01);
        check("first_edge_load", 8'h01);
        tick(2'b01, 1'b0, 1'b0, 8'hFF);
        check("shift_out_right", 0);
        tick(2'b11, 1'b0, 1'b0, 8'h80);
        tick(2'b10, 1'b0, 1'b0, 8'hFF);
        check("shift_out_left", 0);

        for (int i = 0; i < W; i++) tick(2'b10, 1'b1, 1'b0, 8'h00);
        check("fill_sil", 8'hFF);
        for (int i = 0; i < W; i++) tick(2'b01, 1'b1, 1'b0, 8'hFF);
        check("fill_sir0", 8'h00);

        SEL  = 2'b11;
        SRIN = 8'hAA;
        #3 CLEAR = 1'b1;
        @(posedge CK);
        #1 check("clear_vs_edge", 0);
        #2 CLEAR = 1'b0;

        model = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                #2 CLEAR = 1'b1;
                #1 check("rand_clear", 0);
                CLEAR = 1'b0;
                model = 0;
            end else begin
                int s, l, r, d;
                s = int'($urandom_range(0, 3));
                l = int'($urandom_range(0, 1));
                r = int'($urandom_range(0, 1));
                d = int'($urandom_range(0, 255));
                tick(s[1:0], l[0], r[0], d[W-1:0]);
                model = ref_next(model, s, l, r, d);
                check($sformatf("rand_%0d", i), model);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
